// File: rtl/pulse_burst_generator_if.sv
// Interface for pulse_burst_generator: trigger/pulses request in,
// generated waveform and burst status out.
interface pulse_burst_generator_if #(
  parameter int unsigned PW = 4
) ();
  logic          trigger;
  logic [PW-1:0] pulses;
  logic          signal;
  logic          busy;
  logic          done;

  modport master (
    output trigger,
    output pulses,
    input  signal,
    input  busy,
    input  done
  );

  modport slave (
    input  trigger,
    input  pulses,
    output signal,
    output busy,
    output done
  );
endinterface

// File: rtl/pulse_burst_generator.sv
// pulse_burst_generator: on an accepted trigger, emits `pulses` periods of
// HIGH_CYCLES high followed by LOW_CYCLES low on `signal`, holds `busy` for
// the whole burst and strobes `done` for one cycle afterwards.
// Optional macro PULSE_BURST_RETRIGGER_EN: a valid trigger during HIGH/LOW
// restarts the burst with the newly presented pulses value.
module pulse_burst_generator #(
  parameter int unsigned HIGH_CYCLES = 5,
  parameter int unsigned LOW_CYCLES  = 5,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PW          = 4
) (
  input logic                    clk,
  input logic                    reset,
  pulse_burst_generator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [PW-1:0]    r_per;
  logic [PW-1:0]    w_per_nxt;
  logic             r_signal;
  logic             r_busy;
  logic             r_done;
  logic             w_start;

  // Next-state and counter update; phase counter is reloaded at zero so
  // neither counter ever underflows.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_per_nxt   = r_per;
    w_start     = bus.trigger && (bus.pulses != '0);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_per_nxt   = bus.pulses;
          w_phase_nxt = HIGH_LOAD;
          w_state_nxt = S_HIGH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HIGH: begin
        if (r_phase == '0) begin
          w_phase_nxt = LOW_LOAD;
          w_state_nxt = S_LOW;
        end else begin
          w_phase_nxt = r_phase - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (r_phase == '0) begin
          if (r_per > PW'(1)) begin
            w_per_nxt   = r_per - PW'(1);
            w_phase_nxt = HIGH_LOAD;
            w_state_nxt = S_HIGH;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_phase_nxt = r_phase - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef PULSE_BURST_RETRIGGER_EN
    // Restart overrides the normal HIGH/LOW progression; no done for the
    // abandoned burst because DONE is never entered.
    if (w_start && (r_state == S_HIGH || r_state == S_LOW)) begin
      w_per_nxt   = bus.pulses;
      w_phase_nxt = HIGH_LOAD;
      w_state_nxt = S_HIGH;
    end
`endif
  end

  // State/counter registers; outputs are decoded from the next state so they
  // are registered yet aligned with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_per    <= '0;
      r_signal <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_per    <= w_per_nxt;
      r_signal <= (w_state_nxt == S_HIGH);
      r_busy   <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.signal = r_signal;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_pulse_burst_generator.sv
// Testbench for pulse_burst_generator: directed stimulus pushes the expected
// {signal,busy,done} for every cycle into a queue; a monitor pops and
// compares on each falling edge.
module tb_pulse_burst_generator;

  localparam int unsigned HC = 5;
  localparam int unsigned LC = 5;
  localparam int unsigned PW = 4;
`ifdef PULSE_BURST_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk;
  logic reset;

  pulse_burst_generator_if #(.PW(PW)) tif ();

  pulse_burst_generator #(
    .HIGH_CYCLES(HC),
    .LOW_CYCLES (LC),
    .CNT_W      (8),
    .PW         (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {signal, busy, done}
  logic [2:0] expq[$];
  logic [2:0] pend[$];
  logic [2:0] last_exp;
  int         checks;
  int         errors;
  int         cyc;

  function automatic logic [2:0] outs();
    return {tif.signal, tif.busy, tif.done};
  endfunction

  // Monitor: compares DUT outputs with the next queued expectation.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        checks++;
        if (outs() !== e) begin
          errors++;
          $display("FAIL out cyc=%0d got sig/busy/done=%b expected %b", cyc, outs(), e);
        end
      end
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic load_burst(input logic [PW-1:0] p);
    pend.delete();
    for (int unsigned n = 0; n < p; n++) begin
      for (int unsigned i = 0; i < HC; i++) pend.push_back(3'b110);
      for (int unsigned i = 0; i < LC; i++) pend.push_back(3'b010);
    end
    pend.push_back(3'b001);
  endtask

  // One clock: drive inputs, take the edge, queue the expected outputs.
  task automatic step(input logic trg, input logic [PW-1:0] p);
    logic [2:0] e;
    tif.trigger = trg;
    tif.pulses  = p;
    @(posedge clk);
    cyc++;
    if (reset && trg && p != '0 && (!last_exp[1] || RETRIG)) load_burst(p);
    #1;
    e = 3'b000;
    if (reset && pend.size() != 0) e = pend.pop_front();
    last_exp = e;
    expq.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, tif.pulses);
  endtask

  task automatic async_reset_check(input string name);
    reset = 1'b0;
    pend.delete();
    last_exp = 3'b000;
    void'(expq.pop_back());
    expq.push_back(3'b000);
    #1;
    checks++;
    if (outs() !== 3'b000) begin
      errors++;
      $display("FAIL %s got sig/busy/done=%b expected 000", name, outs());
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    last_exp    = 3'b000;
    tif.trigger = 1'b0;
    tif.pulses  = '0;
    reset       = 1'b0;
    #1;
    checks++;
    if (outs() !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got %b expected 000", outs());
    end
    idle(3);
    reset = 1'b1;

    // 1: pulses=3 -> 30 busy cycles, done once after
    idle(9);
    step(1'b1, 4'd3);
    idle(40);

    // 2: pulses=0 trigger is ignored
    step(1'b1, 4'd0);
    idle(50);

    // 3: reset mid-burst, then a fresh pulses=1 burst
    step(1'b1, 4'd3);
    idle(7);
    #1;
    async_reset_check("async_reset_midburst");
    idle(3);
    reset = 1'b1;
    idle(5);
    step(1'b1, 4'd1);
    idle(12);

    // 4: trigger during a burst (restart only with the retrigger macro)
    step(1'b1, 4'd2);
    idle(6);
    step(1'b1, 4'd1);
    idle(25);

    // 5: trigger held high, pulses=1 -> back-to-back bursts
    for (int i = 0; i < 35; i++) step(1'b1, 4'd1);
    idle(12);

    // 6: pulses changes mid-burst without trigger -> still 3 periods
    step(1'b1, 4'd3);
    idle(2);
    tif.pulses = 4'd7;
    idle(32);

    for (int i = 0; i < 10 && expq.size() != 0; i++) @(posedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
